instr_fetch: RTL and testbench

Instruction fetch unit sitting on the read port of the program memory. It steps a program counter and issues `rd_en`/`rd_addr`, then captures `rd_data` one cycle later. Fetched words go into a 2-entry buffer that feeds the decoder over a valid/ready handshake. It supports start, branch redirect with flush, and end-of-program drain.

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: program-memory read port plus the decoder
// valid/ready handshake. The master side is the fetch unit; the slave
// side is the memory/decoder environment.
interface instr_fetch_if #(
    parameter int INSTR_LEN = 20,
    parameter int ADDR      = 5
);
    logic                 rd_en;
    logic [ADDR-1:0]      rd_addr;
    logic [INSTR_LEN-1:0] rd_data;
    logic [INSTR_LEN-1:0] instr;
    logic [ADDR-1:0]      instr_pc;
    logic                 instr_valid;
    logic                 instr_ready;

    modport master (
        output rd_en, rd_addr, instr, instr_pc, instr_valid,
        input  rd_data, instr_ready
    );

    modport slave (
        input  rd_en, rd_addr, instr, instr_pc, instr_valid,
        output rd_data, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: steps a program counter over the program memory
// read port, captures each word one cycle after the read, and queues it in
// a 2-entry FIFO that feeds the decoder over valid/ready. Supports start,
// branch redirect with flush, and an end-of-program drain.
module instr_fetch #(
    parameter int INSTR_LEN = 20,
    parameter int ADDR      = 5,
    parameter int PROG_LEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ADDR-1:0] start_addr,
    input  logic            redirect,
    input  logic [ADDR-1:0] redirect_addr,
    output logic            busy,
    output logic            done,
    instr_fetch_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One extra bit so PROG_LEN == 2**ADDR is still representable.
    localparam logic [ADDR:0]   PROG_END = (ADDR+1)'(PROG_LEN);
    localparam logic [ADDR-1:0] LAST_PC  = ADDR'(PROG_LEN - 1);

    state_t               state_q, state_d;
    logic [ADDR-1:0]      pc_q, pc_d;
    logic                 done_q, done_d;

    // Response stage: a read issued last cycle returns now. rd_addr_q holds
    // the last issued address, which is also the address of that read.
    logic                 inflight_p1;
    logic [ADDR-1:0]      rd_addr_q;

    logic [1:0]           count_q, count_d;
    logic [INSTR_LEN-1:0] buf_data_q [2];
    logic [ADDR-1:0]      buf_pc_q   [2];

    logic                 valid;
    logic                 pop;
    logic                 push;
    logic                 flush;
    logic                 issue;
    logic                 wr_slot;
    logic [2:0]           occupancy;

    // Buffer bookkeeping and the read-issue decision for this cycle.
    always_comb begin
        valid     = (count_q != 2'd0);
        pop       = valid && bus.instr_ready;
        flush     = redirect && (state_q != IDLE);
        // The response arriving in a redirect cycle belongs to the old path.
        push      = inflight_p1 && !flush;
        occupancy = {1'b0, count_q} + {2'b00, inflight_p1} - {2'b00, pop};
        issue     = (state_q == RUN) && !redirect && (occupancy < 3'd2);
        // After the head shifts out, the new word lands in the first free slot.
        wr_slot   = ((count_q - {1'b0, pop}) != 2'd0);
        count_d   = flush ? 2'd0 : (count_q + {1'b0, push} - {1'b0, pop});
    end

    // Next-state, program counter and done-pulse decision.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ({1'b0, start_addr} < PROG_END) begin
                        pc_d    = start_addr;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    pc_d = pc_q + ADDR'(1);
                    if (pc_q == LAST_PC) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Nothing is issued here, so an empty buffer after this edge
                // means the program is fully consumed; done and the busy drop
                // then appear together on the next cycle.
                if (count_d == 2'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            pc_d    = redirect_addr;
            state_d = ({1'b0, redirect_addr} < PROG_END) ? RUN : DRAIN;
            done_d  = 1'b0;
        end
    end

    // FSM state, program counter and registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    // Track the outstanding read and hold the last issued address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_p1 <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            inflight_p1 <= issue;
            if (issue) begin
                rd_addr_q <= pc_q;
            end
        end
    end

    // 2-entry FIFO with the head in slot 0; a pop shifts slot 1 forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            count_q <= count_d;
            if (pop) begin
                buf_data_q[0] <= buf_data_q[1];
                buf_pc_q[0]   <= buf_pc_q[1];
            end
            if (push) begin
                buf_data_q[wr_slot] <= bus.rd_data;
                buf_pc_q[wr_slot]   <= rd_addr_q;
            end
        end
    end

    assign bus.rd_en       = issue;
    assign bus.rd_addr     = issue ? pc_q : rd_addr_q;
    assign bus.instr       = buf_data_q[0];
    assign bus.instr_pc    = buf_pc_q[0];
    assign bus.instr_valid = valid;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus a randomized phase,
// checked every cycle against a queue-based behavioural model.
module tb_instr_fetch;

    localparam int INSTR_LEN = 20;
    localparam int ADDR      = 5;
    localparam int PROG_LEN  = 8;
    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_DRAIN   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [ADDR-1:0] start_addr = '0;
    logic            redirect = 1'b0;
    logic [ADDR-1:0] redirect_addr = '0;
    logic            busy;
    logic            done;

    instr_fetch_if #(.INSTR_LEN(INSTR_LEN), .ADDR(ADDR)) bus ();

    instr_fetch #(.INSTR_LEN(INSTR_LEN), .ADDR(ADDR), .PROG_LEN(PROG_LEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_addr    (start_addr),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .busy          (busy),
        .done          (done),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [INSTR_LEN-1:0] memw(int a);
        return 20'h10000 + 20'(a);
    endfunction

    // Behavioural model state: buffered words as a queue of addresses,
    // one optional outstanding read, the fetch pointer and the mode.
    int q[$];
    bit pend = 1'b0;
    int pend_addr = 0;
    int mpc = 0;
    int last_addr = 0;
    int mode = M_IDLE;
    bit done_exp = 1'b0;

    // Memory request seen this cycle, answered next cycle.
    bit mem_req_en = 1'b0;
    int mem_req_addr = 0;

    // Observation log used by the directed scenarios.
    int got[$];
    int first_valid_cyc = -1;
    int last_xfer = -1;
    int done_cyc = -1;
    int rden_cnt = 0;
    int t_start = 0;
    int t_redir = 0;

    initial begin
        bus.rd_data = '0;
        bus.instr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_en) bus.rd_data = memw(mem_req_addr);
            else            bus.rd_data = 20'($urandom);
        end
    end

    // Compare process: checks the DUT against the model, then advances the model.
    always @(negedge clk) begin
        bit pop;
        bit exp_en;
        int m0;
        if (rst) begin
            chk("rst_rd_en", 32'(bus.rd_en), 0);
            chk("rst_rd_addr", 32'(bus.rd_addr), 0);
            chk("rst_instr", 32'(bus.instr), 0);
            chk("rst_instr_pc", 32'(bus.instr_pc), 0);
            chk("rst_instr_valid", 32'(bus.instr_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            q.delete();
            pend = 1'b0;
            mpc = 0;
            last_addr = 0;
            mode = M_IDLE;
            done_exp = 1'b0;
            mem_req_en = 1'b0;
        end else begin
            m0 = mode;
            pop = (q.size() != 0) && bus.instr_ready;
            exp_en = (m0 == M_RUN) && !redirect && ((q.size() + int'(pend) - int'(pop)) < 2);
            chk("rd_en", 32'(bus.rd_en), 32'(exp_en));
            chk("rd_addr", 32'(bus.rd_addr), 32'(exp_en ? mpc : last_addr));
            chk("instr_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("instr_pc", 32'(bus.instr_pc), 32'(q[0]));
                chk("instr", 32'(bus.instr), 32'(memw(q[0])));
            end
            chk("busy", 32'(busy), 32'(m0 != M_IDLE));
            chk("done", 32'(done), 32'(done_exp));
            chk("count_le2", 32'(dut.count_q <= 2'd2), 1);

            if (bus.rd_en) rden_cnt++;
            if (bus.instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.instr_valid && bus.instr_ready) begin
                got.push_back(int'(bus.instr_pc));
                last_xfer = cyc;
            end
            if (done) done_cyc = cyc;
            mem_req_en = bus.rd_en;
            mem_req_addr = int'(bus.rd_addr);

            done_exp = 1'b0;
            if (pop) void'(q.pop_front());
            if (m0 != M_IDLE && redirect) begin
                q.delete();
                pend = 1'b0;
                mpc = int'(redirect_addr);
                mode = (int'(redirect_addr) < PROG_LEN) ? M_RUN : M_DRAIN;
            end else begin
                if (pend) q.push_back(pend_addr);
                if (exp_en) last_addr = mpc;
                pend = exp_en;
                pend_addr = mpc;
                if (exp_en) begin
                    if (mpc == PROG_LEN - 1) mode = M_DRAIN;
                    mpc++;
                end else if (m0 == M_DRAIN && q.size() == 0 && !pend) begin
                    mode = M_IDLE;
                    done_exp = 1'b1;
                end
                if (m0 == M_IDLE && start) begin
                    if (int'(start_addr) < PROG_LEN) begin
                        mode = M_RUN;
                        mpc = int'(start_addr);
                    end else begin
                        done_exp = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_got(string tag, input int exp[$]);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk({tag, "_pc"}, 32'(got[i]), 32'(exp[i]));
        end
    endtask

    task automatic run(input int saddr, input bit bp, output bit seen);
        tick();
        start = 1'b1;
        start_addr = 5'(saddr);
        instr_ready_set(1'b1);
        t_start = cyc;
        first_valid_cyc = -1;
        done_cyc = -1;
        got.delete();
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            start = 1'b0;
            if (bp) begin
                instr_ready_set((k % 4 == 0) || (k % 4 == 3));
                if (k == 5) begin
                    start = 1'b1;
                    start_addr = 5'd5;
                end
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic instr_ready_set(input bit v);
        bus.instr_ready = v;
    endtask

    initial begin
        bit seen;
        bit fired;
        int e[$];

        // Reset held for a few cycles, then released.
        rst = 1'b1;
        repeat (3) tick();
        chk("init_busy", 32'(busy), 0);
        chk("init_rd_en", 32'(bus.rd_en), 0);
        rst = 1'b0;
        tick();

        // Linear run from 0 with the decoder always ready.
        run(0, 1'b0, seen);
        chk("lin_done_seen", 32'(seen), 1);
        chk("lin_latency", 32'(first_valid_cyc - t_start), 3);
        chk("lin_done_gap", 32'(done_cyc - last_xfer), 1);
        e = {0, 1, 2, 3, 4, 5, 6, 7};
        chk_got("lin", e);

        // Backpressure 1,0,0,1 with a start attempt while busy.
        run(0, 1'b1, seen);
        chk("bp_done_seen", 32'(seen), 1);
        e = {0, 1, 2, 3, 4, 5, 6, 7};
        chk_got("bp", e);

        // Redirect to 6 during the transfer of pc 2.
        tick();
        start = 1'b1;
        start_addr = 5'd0;
        instr_ready_set(1'b1);
        got.delete();
        done_cyc = -1;
        seen = 1'b0;
        fired = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            start = 1'b0;
            redirect = 1'b0;
            if (!fired && bus.instr_valid && bus.instr_pc == 5'd2) begin
                redirect = 1'b1;
                redirect_addr = 5'd6;
                t_redir = cyc;
                fired = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        redirect = 1'b0;
        @(negedge clk);
        #1;
        chk("redir_fired", 32'(fired), 1);
        chk("redir_done_seen", 32'(seen), 1);
        e = {0, 1, 2, 6, 7};
        chk_got("redir", e);

        // Redirect out of range during the transfer of pc 1.
        tick();
        start = 1'b1;
        start_addr = 5'd0;
        got.delete();
        done_cyc = -1;
        seen = 1'b0;
        fired = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            start = 1'b0;
            redirect = 1'b0;
            if (!fired && bus.instr_valid && bus.instr_pc == 5'd1) begin
                redirect = 1'b1;
                redirect_addr = 5'd31;
                t_redir = cyc;
                fired = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        redirect = 1'b0;
        @(negedge clk);
        #1;
        chk("oor_fired", 32'(fired), 1);
        chk("oor_done_seen", 32'(seen), 1);
        chk("oor_done_within2", 32'((done_cyc - t_redir) >= 1 && (done_cyc - t_redir) <= 2), 1);
        chk("oor_idle", 32'(busy), 0);
        e = {0, 1};
        chk_got("oor", e);

        // Start at PROG_LEN: done next cycle, no read.
        tick();
        start = 1'b1;
        start_addr = 5'd8;
        t_start = cyc;
        done_cyc = -1;
        rden_cnt = 0;
        got.delete();
        tick();
        start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        chk("sOOR_done_cyc", 32'(done_cyc - t_start), 1);
        chk("sOOR_no_rd_en", 32'(rden_cnt), 0);
        chk("sOOR_busy", 32'(busy), 0);

        // Async reset mid-run with the buffer full.
        tick();
        start = 1'b1;
        start_addr = 5'd0;
        instr_ready_set(1'b0);
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("pre_rst_count", 32'(dut.count_q), 2);
        chk("pre_rst_valid", 32'(bus.instr_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rd_en", 32'(bus.rd_en), 0);
        chk("arst_rd_addr", 32'(bus.rd_addr), 0);
        chk("arst_instr", 32'(bus.instr), 0);
        chk("arst_instr_pc", 32'(bus.instr_pc), 0);
        chk("arst_valid", 32'(bus.instr_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        run(3, 1'b0, seen);
        chk("post_rst_done_seen", 32'(seen), 1);
        e = {3, 4, 5, 6, 7};
        chk_got("post_rst", e);

        // Randomized traffic: backpressure, starts, redirects in and out of range.
        for (int k = 0; k < 1500; k++) begin
            tick();
            instr_ready_set($urandom_range(0, 3) != 0);
            start = 1'b0;
            redirect = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                start_addr = 5'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 15) == 0) begin
                redirect = 1'b1;
                redirect_addr = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 8));
            end
        end
        tick();
        start = 1'b0;
        redirect = 1'b0;
        instr_ready_set(1'b1);
        for (int k = 0; k < 40 && busy; k++) tick();
        chk("rand_drained", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
